mem_access_unit: RTL and testbench

- Pipelined MEM-stage unit for the MIPS core. Replaces the single-cycle data access path with a request/acknowledge data-memory interface of variable latency.
- Adds three capabilities: byte-lane write enables for SB/SH, lane extraction for sub-word loads, and alignment and timeout error detection.
- Also resolves BEQ/BNE. pcSrc_out and data_out are registered alongside a valid_out pulse. The stage sits between EX/MEM and MEM/WB.

---
 rtl/mips_mem_pkg.sv | 26 ++
 rtl/load_align.sv | 28 ++
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared MEM-stage definitions: MIPS load/store opcodes, access-size encodings
// and the request FSM states.
package mips_mem_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LWU = 6'b100111;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  // SZ_DWORD is only produced internally, for a 64-bit datapath
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b11;
  localparam logic [1:0] SZ_DWORD = 2'b10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load lane extraction: picks the byte/half/word at a byte lane
// of a memory word and sign- or zero-extends it to the full datapath width.
module load_align
  import mips_mem_pkg::*;
#(
  parameter int B = 32
) (
  input  logic [B-1:0]             rdata,
  input  logic [$clog2(B/8)-1:0]   lane,
  input  logic [1:0]               size,
  input  logic                     uns,
  output logic [B-1:0]             data
);

  logic [B-1:0] sh;

  assign sh = rdata >> {lane, 3'b000};

  always_comb begin
    case (size)
      SZ_BYTE: data = uns ? B'(sh[7:0])  : B'($signed(sh[7:0]));
      SZ_HALF: data = uns ? B'(sh[15:0]) : B'($signed(sh[15:0]));
      SZ_WORD: data = uns ? B'(sh[31:0]) : B'($signed(sh[31:0]));
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS MEM stage: request/acknowledge data-memory access with byte-lane
// stores, extended sub-word loads, alignment/timeout errors and BEQ/BNE.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int B       = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [AW-1:0]    addr_in,
  input  logic [B-1:0]     write_data,
  input  logic [5:0]       opcode,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic             zero,
  input  logic             branch_in,
  input  logic             branchNot_in,
  output logic             mem_req,
  output logic [B/8-1:0]   mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [B-1:0]     mem_wdata,
  input  logic [B-1:0]     mem_rdata,
  input  logic             mem_ack,
  output logic             stall_out,
  output logic             valid_out,
  output logic [B-1:0]     data_out,
  output logic             pcSrc_out,
  output logic             misalign_out,
  output logic             bus_err_out
);

  localparam int NBYTES = B / 8;
  localparam int LW     = $clog2(NBYTES);
  localparam int CW     = $clog2(TIMEOUT) + 1;

  state_t            state, state_nxt;
  logic [1:0]        size;
  logic [LW-1:0]     lane;
  logic              aligned, is_mem, accept, start, timed_out;
  logic [NBYTES-1:0] we_nxt;
  logic [B-1:0]      wdata_nxt, ld_data;
  logic [CW-1:0]     cnt;
  logic [1:0]        size_p1;
  logic [LW-1:0]     lane_p1;
  logic              uns_p1, load_p1;
  logic              unused_opcode;

  // opcode class bits are carried by mem_read/mem_write instead
  assign unused_opcode = ^opcode[5:3];

  assign lane      = addr_in[LW-1:0];
  assign is_mem    = mem_read | mem_write;
  assign accept    = valid_in & (state == S_IDLE);
  assign start     = accept & is_mem & aligned;
  assign timed_out = (state == S_WAIT) & ~mem_ack & (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    case (opcode[1:0])
      2'b00:   size = SZ_BYTE;
      2'b01:   size = SZ_HALF;
      default: size = (B == 64 && opcode[4]) ? SZ_DWORD : SZ_WORD;
    endcase
  end

  always_comb begin
    case (size)
      SZ_BYTE: aligned = 1'b1;
      SZ_HALF: aligned = ~addr_in[0];
      SZ_WORD: aligned = (addr_in[1:0] == 2'b00);
      default: aligned = (addr_in[2:0] == 3'b000);
    endcase
  end

  always_comb begin
    we_nxt    = '0;
    wdata_nxt = write_data;
    case (size)
      SZ_BYTE: begin
        we_nxt    = NBYTES'(1) << lane;
        wdata_nxt = {NBYTES{write_data[7:0]}};
      end
      SZ_HALF: begin
        we_nxt    = NBYTES'(3) << lane;
        wdata_nxt = {(NBYTES/2){write_data[15:0]}};
      end
      SZ_WORD: begin
        we_nxt    = NBYTES'(15) << lane;
        wdata_nxt = {(NBYTES/4){write_data[31:0]}};
      end
      default: we_nxt = '1;
    endcase
    if (!mem_write) we_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_WAIT;
      S_WAIT:  if (mem_ack || timed_out) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stall_out = start | (state == S_WAIT);
  end

  load_align #(.B(B)) u_load_align (
    .rdata (mem_rdata),
    .lane  (lane_p1),
    .size  (size_p1),
    .uns   (uns_p1),
    .data  (ld_data)
  );

  // request issue (p0 -> p1) and completion (p1 -> result)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req      <= 1'b0;
      mem_we       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      valid_out    <= 1'b0;
      data_out     <= '0;
      pcSrc_out    <= 1'b0;
      misalign_out <= 1'b0;
      bus_err_out  <= 1'b0;
      cnt          <= '0;
      size_p1      <= SZ_BYTE;
      lane_p1      <= '0;
      uns_p1       <= 1'b0;
      load_p1      <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (state == S_IDLE) begin
        if (accept && !start) begin
          valid_out    <= 1'b1;
          pcSrc_out    <= (branch_in & zero) | (branchNot_in & ~zero);
          misalign_out <= is_mem & ~aligned;
          bus_err_out  <= 1'b0;
          data_out     <= '0;
        end
        if (start) begin
          mem_req   <= 1'b1;
          mem_we    <= we_nxt;
          mem_addr  <= {addr_in[AW-1:LW], LW'(0)};
          mem_wdata <= wdata_nxt;
          cnt       <= '0;
          size_p1   <= size;
          lane_p1   <= lane;
          uns_p1    <= opcode[2];
          load_p1   <= mem_read & ~mem_write;
        end
      end else begin
        cnt <= cnt + CW'(1);
        if (mem_ack || timed_out) begin
          mem_req      <= 1'b0;
          mem_we       <= '0;
          valid_out    <= 1'b1;
          pcSrc_out    <= 1'b0;
          misalign_out <= 1'b0;
          bus_err_out  <= ~mem_ack;
          data_out     <= (mem_ack && load_p1) ? ld_data : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: drives loads, stores, branches, misaligned ops,
// a timeout and a mid-transaction reset; results are checked from a queue.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  localparam int B       = 32;
  localparam int AW      = 32;
  localparam int TIMEOUT = 16;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [B-1:0]  write_data = '0;
  logic [5:0]    opcode = '0;
  logic          mem_read = 1'b0, mem_write = 1'b0, zero = 1'b0;
  logic          branch_in = 1'b0, branchNot_in = 1'b0;
  logic          mem_req;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [B-1:0]  mem_wdata;
  logic [B-1:0]  mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          stall_out, valid_out, pcSrc_out, misalign_out, bus_err_out;
  logic [B-1:0]  data_out;

  always #5 clk = ~clk;

  mem_access_unit #(.B(B), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .addr_in(addr_in),
    .write_data(write_data), .opcode(opcode), .mem_read(mem_read),
    .mem_write(mem_write), .zero(zero), .branch_in(branch_in),
    .branchNot_in(branchNot_in), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall_out(stall_out), .valid_out(valid_out),
    .data_out(data_out), .pcSrc_out(pcSrc_out), .misalign_out(misalign_out),
    .bus_err_out(bus_err_out)
  );

  typedef struct packed {
    logic        pc;
    logic        mis;
    logic        err;
    logic [31:0] data;
  } res_t;

  res_t exp_q[$];
  res_t mon_r;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t mk(input logic pc, mis, err, input logic [31:0] data);
    res_t r;
    r.pc = pc; r.mis = mis; r.err = err; r.data = data;
    return r;
  endfunction

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        mon_r = exp_q.pop_front();
        chk("res_pc",   pcSrc_out,    mon_r.pc);
        chk("res_mis",  misalign_out, mon_r.mis);
        chk("res_err",  bus_err_out,  mon_r.err);
        chk("res_data", data_out,     mon_r.data);
      end
    end
  end

  task automatic drive(input logic [5:0] opc, input logic [31:0] addr, wd,
                       input logic rd, wr, z, beq, bne);
    opcode = opc; addr_in = addr; write_data = wd; mem_read = rd;
    mem_write = wr; zero = z; branch_in = beq; branchNot_in = bne;
    valid_in = 1'b1;
  endtask

  task automatic clear_in();
    valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    branch_in = 1'b0; branchNot_in = 1'b0;
  endtask

  task automatic do_simple(input string tag, input logic [5:0] opc, input logic [31:0] addr,
                           input logic rd, wr, z, beq, bne, input res_t r);
    @(negedge clk);
    drive(opc, addr, 32'h0, rd, wr, z, beq, bne);
    #1 chk({tag, "_stall"}, stall_out, 0);
    exp_q.push_back(r);
    @(negedge clk);
    clear_in();
    chk({tag, "_vld"}, valid_out, 1);
    chk({tag, "_req"}, mem_req, 0);
  endtask

  task automatic do_mem(input string tag, input logic [5:0] opc, input logic [31:0] addr, wd,
                        input logic rd, wr, input int dly, input logic [31:0] rdata,
                        input logic [3:0] we_x, input logic [31:0] addr_x, wd_x,
                        input res_t r);
    @(negedge clk);
    drive(opc, addr, wd, rd, wr, 1'b0, 1'b0, 1'b0);
    #1 chk({tag, "_stall_acc"}, stall_out, 1);
    exp_q.push_back(r);
    @(negedge clk);
    clear_in();
    for (int k = 1; k <= dly; k++) begin
      chk({tag, "_req"},   mem_req,   1);
      chk({tag, "_we"},    mem_we,    we_x);
      chk({tag, "_addr"},  mem_addr,  addr_x);
      chk({tag, "_wdata"}, mem_wdata, wd_x);
      chk({tag, "_stall"}, stall_out, 1);
      chk({tag, "_early"}, valid_out, 0);
      if (k == dly) begin
        mem_ack = 1'b1;
        mem_rdata = rdata;
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end
    chk({tag, "_vld"},      valid_out, 1);
    chk({tag, "_req_drop"}, mem_req,   0);
    chk({tag, "_unstall"},  stall_out, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req",   mem_req,      0);
    chk("rst_vld",   valid_out,    0);
    chk("rst_stall", stall_out,    0);
    chk("rst_we",    mem_we,       0);
    chk("rst_data",  data_out,     0);
    chk("rst_pc",    pcSrc_out,    0);
    chk("rst_mis",   misalign_out, 0);
    chk("rst_err",   bus_err_out,  0);
    rst_n = 1'b1;
    @(negedge clk);

    do_mem("sw", OP_SW, 32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 3, 32'h0,
           4'hF, 32'h10, 32'hDEADBEEF, mk(0, 0, 0, 32'h0));
    do_mem("sb", OP_SB, 32'h13, 32'h000000A5, 1'b0, 1'b1, 2, 32'h0,
           4'b1000, 32'h10, 32'hA5A5A5A5, mk(0, 0, 0, 32'h0));
    do_mem("sh", OP_SH, 32'h12, 32'h00001234, 1'b0, 1'b1, 1, 32'h0,
           4'b1100, 32'h10, 32'h12341234, mk(0, 0, 0, 32'h0));

    do_mem("lb", OP_LB, 32'h12, 32'h0, 1'b1, 1'b0, 1, 32'h80FF7F01,
           4'h0, 32'h10, 32'h0, mk(0, 0, 0, 32'hFFFFFFFF));
    do_mem("lbu", OP_LBU, 32'h13, 32'h0, 1'b1, 1'b0, 1, 32'h80FF7F01,
           4'h0, 32'h10, 32'h0, mk(0, 0, 0, 32'h00000080));
    do_mem("lh", OP_LH, 32'h02, 32'h0, 1'b1, 1'b0, 1, 32'h80FF7F01,
           4'h0, 32'h00, 32'h0, mk(0, 0, 0, 32'hFFFF80FF));
    do_mem("lhu", OP_LHU, 32'h00, 32'h0, 1'b1, 1'b0, 1, 32'h80FF7F01,
           4'h0, 32'h00, 32'h0, mk(0, 0, 0, 32'h00007F01));
    do_mem("lb_pos", OP_LB, 32'h11, 32'h0, 1'b1, 1'b0, 1, 32'h80FF7F01,
           4'h0, 32'h10, 32'h0, mk(0, 0, 0, 32'h0000007F));
    // ack in the final allowed cycle must complete normally
    do_mem("lw_lastack", OP_LW, 32'h14, 32'h0, 1'b1, 1'b0, TIMEOUT, 32'h80FF7F01,
           4'h0, 32'h14, 32'h0, mk(0, 0, 0, 32'h80FF7F01));

    do_simple("lw_mis", OP_LW, 32'h06, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 32'h0));
    do_simple("sh_mis", OP_SH, 32'h01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, mk(0, 1, 0, 32'h0));
    do_simple("bne_nz", OP_BNE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, mk(1, 0, 0, 32'h0));
    do_simple("beq_nz", OP_BEQ, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 32'h0));
    do_simple("beq_z",  OP_BEQ, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(1, 0, 0, 32'h0));

    @(negedge clk);
    drive(OP_LW, 32'h20, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_q.push_back(mk(0, 0, 1, 32'h0));
    @(negedge clk);
    clear_in();
    for (int k = 1; k <= TIMEOUT; k++) begin
      chk("to_req", mem_req, 1);
      @(negedge clk);
    end
    chk("to_vld", valid_out, 1);
    chk("to_req_drop", mem_req, 0);
    mem_ack = 1'b1;
    mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("late_ack_vld", valid_out, 0);
    chk("late_ack_req", mem_req, 0);

    @(negedge clk);
    drive(OP_LW, 32'h30, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    clear_in();
    chk("wait_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_req", mem_req, 0);
    chk("async_rst_stall", stall_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("post_rst_vld", valid_out, 0);
      chk("post_rst_req", mem_req, 0);
      @(negedge clk);
    end

    chk("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
